// File: rtl/cim_shift_acc.sv
// cim_shift_acc: bit-serial shift-accumulator for a compute-in-memory column.
// Each accepted beat carries an active-low partial product (p = ~pp_n) for one
// input bit. The beat is added at weight 2^k. After IN_BITS beats for each of
// NUM_WORDS words, the total is presented on out_data with a valid/ready handshake.
// Optional macro CIM_SIGNED_EN: treat p as two's complement. The beat at
// k = IN_BITS-1 is then subtracted, because the input MSB has negative weight.
// Assumes ACC_W > 4.
module cim_shift_acc #(
    parameter int IN_BITS   = 4,
    parameter int NUM_WORDS = 4,
    parameter int ACC_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       pp_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    localparam int KW = (IN_BITS   > 1) ? $clog2(IN_BITS)   : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] out_data_q;
    logic [KW-1:0]    k_q;
    logic [WW-1:0]    word_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [3:0]       p;
    logic [ACC_W-1:0] v;
    logic [ACC_W-1:0] term;
    logic             last_bit;
    logic             last_word;
    logic             beat;

    assign p         = ~pp_n;
    assign last_bit  = (k_q == KW'(IN_BITS - 1));
    assign last_word = (word_q == WW'(NUM_WORDS - 1));
    assign beat      = in_valid && in_ready_q && !clr;

    // Widen the partial product to ACC_W and shift it to the weight of the current bit.
    always_comb begin
`ifdef CIM_SIGNED_EN
        v = {{(ACC_W - 4){p[3]}}, p};
`else
        v = {{(ACC_W - 4){1'b0}}, p};
`endif
        term = v << k_q;
    end

    // Next accumulator value, modulo 2^ACC_W. In signed mode the MSB beat is subtracted.
    always_comb begin
`ifdef CIM_SIGNED_EN
        acc_d = last_bit ? (acc_q - term) : (acc_q + term);
`else
        acc_d = acc_q + term;
`endif
    end

    // Control FSM, counters, accumulator and registered outputs.
    // Priority is rst, then clr, then beat acceptance or the output handshake.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            k_q         <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (beat) begin
                        if (last_bit) begin
                            k_q <= '0;
                            if (last_word) begin
                                // Final beat: publish the total. The accumulator is free for the next result.
                                word_q      <= '0;
                                acc_q       <= '0;
                                out_data_q  <= acc_d;
                                state_q     <= ST_DONE;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                word_q <= word_q + 1'b1;
                                acc_q  <= acc_d;
                            end
                        end else begin
                            k_q   <= k_q + 1'b1;
                            acc_q <= acc_d;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold the result until the consumer takes it. in_valid is ignored here.
                    if (out_ready) begin
                        out_data_q  <= '0;
                        state_q     <= ST_ACC;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_ACC;
                    acc_q       <= '0;
                    k_q         <= '0;
                    word_q      <= '0;
                    out_data_q  <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cim_shift_acc.sv
// Testbench for cim_shift_acc (default parameters). Compile with the same
// CIM_SIGNED_EN setting as the design so the reference model matches.
module tb_cim_shift_acc;

    localparam int IN_BITS   = 4;
    localparam int NUM_WORDS = 4;
    localparam int ACC_W     = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       pp_n;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    cim_shift_acc #(
        .IN_BITS  (IN_BITS),
        .NUM_WORDS(NUM_WORDS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pp_n     (pp_n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit rnd_ready = 1'b0;

    // Reference model: a dot product built from weighted bits, plus a queue of expected results.
    int           m_acc  = 0;
    int           m_k    = 0;
    int           m_word = 0;
    logic [31:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Add one beat to the model. The beat's value is p * 2^k. In signed mode, p is a
    // 4-bit two's-complement value and the top input bit has weight -2^(IN_BITS-1).
    task automatic model_beat(input logic [3:0] pp);
        int pv;
        int weight;
        pv = int'(~pp & 4'hF);
`ifdef CIM_SIGNED_EN
        if (pv >= 8) pv = pv - 16;
        weight = (m_k == IN_BITS - 1) ? -(1 << m_k) : (1 << m_k);
`else
        weight = 1 << m_k;
`endif
        m_acc = m_acc + pv * weight;
        m_k++;
        if (m_k == IN_BITS) begin
            m_k = 0;
            m_word++;
            if (m_word == NUM_WORDS) begin
                exp_q.push_back(32'(m_acc) & 32'hFFF);
                m_acc  = 0;
                m_word = 0;
            end
        end
    endtask

    // A clear or reset discards the partial sum and any result still pending.
    task automatic model_clear();
        m_acc  = 0;
        m_k    = 0;
        m_word = 0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    // Monitor: checks outputs every cycle and pops the queue when a handshake will occur.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                chk("done_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_data", 32'(out_data), exp_q[0]);
                    if (out_ready && !clr && !rst) begin
                        void'(exp_q.pop_front());
                        $display("result taken: out_data=0x%03h at %0t", out_data, $time);
                    end
                end
            end else begin
                chk("idle_out_data", 32'(out_data), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
                if (exp_q.size() != 0) chk("missing_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    // Offer one beat. Wait, with a bound, until the DUT is ready; it is accepted on the next edge.
    task automatic beat(input logic [3:0] pp);
        int waited;
        bit ok;
        waited   = 0;
        ok       = 1'b1;
        in_valid = 1'b1;
        pp_n     = pp;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 64) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        if (ok) begin
            @(posedge clk);
            model_beat(pp);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr      = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        pp_n     = 4'($urandom_range(0, 15));
        @(posedge clk);
        model_clear();
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic rst_pulse();
        rst      = 1'b1;
        clr      = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        rst      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    // w=6 and x=5: beats 1001, 1111, 1001, 1111 for each of the words.
    task automatic seq_w6x5(input int nbeats);
        for (int i = 0; i < nbeats; i++) beat((i % 2 == 0) ? 4'b1001 : 4'b1111);
    endtask

    // Check the result one cycle after the last beat, then let the handshake complete.
    task automatic check_done(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_max;
        logic [31:0] exp_sgn;
        int          drain;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; pp_n = 4'hF; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic unsigned dot product.
        seq_w6x5(16);
        check_done("req028", 32'h078);
        @(negedge clk);
        chk("req028_back_to_acc", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: the result must stay put while beats are offered.
        out_ready = 1'b0;
        seq_w6x5(16);
        in_valid = 1'b1;
        pp_n     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h078);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Clear after two beats, then a full sequence.
        seq_w6x5(2);
        clr_pulse();
        seq_w6x5(16);
        check_done("req030", 32'h078);

        // Maximum operands.
`ifdef CIM_SIGNED_EN
        exp_max = 32'd4;
        exp_sgn = 32'h018;
`else
        exp_max = 32'h384;
        exp_sgn = 32'h2D8;
`endif
        for (int i = 0; i < 16; i++) beat(4'b0000);
        check_done("req031", exp_max);

        // w=-3 and x=-2.
        for (int w = 0; w < 4; w++) begin
            beat(4'b1111);
            beat(4'b0010);
            beat(4'b0010);
            beat(4'b0010);
        end
        check_done("req032", exp_sgn);

        // Reset at beat 10.
        seq_w6x5(10);
        rst_pulse();
        @(negedge clk);
        chk("req033_rst_valid", 32'(out_valid), 32'd0);
        chk("req033_rst_data", 32'(out_data), 32'd0);
        chk("req033_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        seq_w6x5(16);
        check_done("req033", 32'h078);

        // Randomized traffic with backpressure, gaps, clears and resets.
        rnd_ready = 1'b1;
        for (int n = 0; n < 700; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            out_ready = 1'($urandom_range(0, 1));
            if (r < 85) begin
                beat(4'($urandom_range(0, 15)));
            end else if (r < 89) begin
                clr_pulse();
            end else if (r < 91) begin
                rst_pulse();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(posedge clk);
            #1;
            drain++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_shift_acc.md
CIM_SHIFT_ACC -- requirements
Module: cim_shift_acc

Interface
REQ-001 SHALL have parameter IN_BITS, default 4, meaning serial input-bit beats per word (LSB first).
REQ-002 SHALL have parameter NUM_WORDS, default 4, meaning words accumulated per result.
REQ-003 SHALL have parameter ACC_W, default 12, meaning accumulator/result width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous abort/clear of current accumulation.
REQ-007 SHALL have port in_valid  input  1  beat present on pp_n.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port pp_n  input  4  active-low partial product from the OAI multiplier column; true product p = ~pp_n.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_data  output  ACC_W  accumulated dot-product result.

Function
REQ-013 SHALL implement two states: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 SHALL accept a beat only when in_valid && in_ready && !clr.
REQ-015 SHALL keep bit counter k (0..IN_BITS-1) and word counter (0..NUM_WORDS-1), both advancing only on accepted beats; k wraps to 0 and word counter increments after beat IN_BITS-1.
REQ-016 SHALL on each accepted beat add v<<k to the accumulator, v = p zero-extended to ACC_W (unsigned mode).
REQ-017 SHALL perform all arithmetic modulo 2^ACC_W; overflow wraps silently, no flag.
REQ-018 SHALL, on acceptance of beat k=IN_BITS-1 of word NUM_WORDS-1, enter DONE the next cycle with out_data = final accumulator (one-cycle latency from last beat).
REQ-019 SHALL hold out_data and out_valid stable in DONE while out_ready=0; in_valid ignored.
REQ-020 SHALL on out_valid && out_ready clear accumulator and both counters and return to ACC next cycle; first new beat accepted no earlier than that cycle.
REQ-021 SHALL on clr=1 (either state) clear accumulator and counters, return to ACC next cycle; clr beats are discarded; clr in DONE drops the pending result.
REQ-022 SHALL drive out_data from a register; out_data = 0 whenever not in DONE.

Reset
REQ-023 SHALL on rst=1 at a clock edge enter ACC with accumulator=0, k=0, word counter=0, out_valid=0, out_data=0, in_ready=1 (after the edge).
REQ-024 SHALL give rst priority over clr, clr over beat acceptance and output handshake.
REQ-025 SHALL discard any partial accumulation when rst asserts mid-word or in DONE.

Configuration
REQ-026 SHALL honour macro CIM_SIGNED_EN: when defined, p is two's-complement (bit3 weight -8, sign-extended to ACC_W) and the beat at k=IN_BITS-1 is subtracted (input MSB weight negative); otherwise all operands unsigned per REQ-016.
REQ-027 SHALL keep ports, timing and handshake identical with and without CIM_SIGNED_EN.

Verification (defaults IN_BITS=4, NUM_WORDS=4, ACC_W=12)
REQ-028 SHALL cover unsigned: 4 words of w=6, x=5 (pp_n beats 1001,1111,1001,1111), out_ready=1 -> out_valid one cycle after 16th beat, out_data=120 (0x078).
REQ-029 SHALL cover backpressure: after REQ-028 result, out_ready=0 for 3 cycles with in_valid=1 -> out_valid/out_data=0x078 stable, in_ready=0, no beats consumed; out_ready=1 -> ACC next cycle, accumulator 0.
REQ-030 SHALL cover clr after 2 beats of word 0, then full REQ-028 sequence -> out_data=0x078.
REQ-031 SHALL cover max unsigned: 16 beats pp_n=0000 (w=15, x=15) -> out_data=900 (0x384).
REQ-032 SHALL cover CIM_SIGNED_EN: 4 words w=-3 (p=1101), x=-2 (bits 0,1,1,1: pp_n 1111,0010,0010,0010) -> out_data=24 (0x018); same stimulus without macro -> 728 (0x2D8).
REQ-033 SHALL cover rst at beat 10 then full REQ-028 sequence -> outputs reset next cycle, final out_data=0x078.
